// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, MSB first, with a forced idle gap between words.
// Optional even-parity bit after the data bits when SERIAL_WORD_TX_PARITY_EN is defined.
module serial_word_tx #(
  parameter int   WIDTH      = 8,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

`ifdef SERIAL_WORD_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
`ifdef SERIAL_WORD_TX_PARITY_EN
  logic             parity;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = SHIFT;
      SHIFT: if (bit_cnt == BIT_LAST) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
        state_nxt = PARITY;
`else
        state_nxt = HAS_GAP ? GAP : IDLE;
`endif
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      PARITY: state_nxt = HAS_GAP ? GAP : IDLE;
`endif
      GAP:   if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: the word and its parity are captured only on an IDLE accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shift_reg <= in_data;
          bit_cnt   <= '0;
          gap_cnt   <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
          parity    <= ^in_data;
`endif
        end
        SHIFT: begin
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          bit_cnt   <= bit_cnt + BW'(1);
          gap_cnt   <= '0;
        end
        GAP:     gap_cnt <= gap_cnt + GW'(1);
        default: gap_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    ser_out   = IDLE_LEVEL;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:  in_ready = !rst;
      SHIFT: begin
        ser_out   = shift_reg[WIDTH-1];
        ser_valid = 1'b1;
        busy      = 1'b1;
`ifndef SERIAL_WORD_TX_PARITY_EN
        ser_last  = (bit_cnt == BIT_LAST);
`endif
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      PARITY: begin
        ser_out   = parity;
        ser_valid = 1'b1;
        ser_last  = 1'b1;
        busy      = 1'b1;
      end
`endif
      GAP:     busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial front end for the serial pattern detectors in the FSM block set.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk, MSB first, on ser_out.
- Between words ser_out is driven to IDLE_LEVEL, so a downstream detector sees a defined line level and no spurious bits.

Parameters:
WIDTH  8  word width in bits (>=2)
GAP_CYCLES  1  idle cycles forced after each word's last bit, before the next word is accepted (0 allowed)
IDLE_LEVEL  1'b1  value driven on ser_out whenever no data bit is being sent

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
in_data  in  WIDTH  parallel word to transmit
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a word this cycle
ser_out  out  1  serial bit stream to detector data_in
ser_valid  out  1  ser_out carries a data (or parity) bit this cycle
ser_last  out  1  current bit is the final bit of the word
busy  out  1  word in flight (SHIFT, PARITY or GAP state)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- While rst is high, at the clock edge: state<=IDLE, shift_reg<=0, bit_cnt<=0, gap_cnt<=0.
- Output values during and after reset:
  - ser_out=IDLE_LEVEL, ser_valid=0, ser_last=0, busy=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
- States: IDLE, SHIFT, PARITY (only with the optional feature), GAP.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: shift_reg<=in_data, bit_cnt<=0, go to SHIFT.
- SHIFT:
  - ser_out=shift_reg[WIDTH-1], ser_valid=1, in_ready=0.
  - Each edge: shift_reg shifts left with a 0 fill, and bit_cnt increments.
  - ser_last=1 when bit_cnt==WIDTH-1.
  - After the last bit, next state is PARITY if enabled; otherwise GAP if GAP_CYCLES>0; otherwise IDLE.
- GAP:
  - ser_out=IDLE_LEVEL, ser_valid=0, in_ready=0.
  - Stays GAP_CYCLES cycles (gap_cnt counts 0..GAP_CYCLES-1), then IDLE.
- Output timing: all outputs are decoded combinationally from registered state/shift_reg only (Moore). No input-to-output combinational path except in_ready's dependence on rst.
- Latency:
  - Word accepted at edge N → bit k (MSB = k=0) is present during the cycle after edge N+k.
  - in_ready reasserts GAP_CYCLES+1 cycles after the last bit's cycle ends (the GAP cycles plus the IDLE cycle in which the next accept happens).
  - Minimum spacing between words is GAP_CYCLES+1 cycles of IDLE_LEVEL.
- Handshake rules:
  - The producer holds in_data stable while in_valid=1 until accepted.
  - in_valid while busy is ignored, with no effect on the word in flight.
  - in_valid deasserting before acceptance is legal; nothing is captured.
- Reset mid-word: aborts immediately. The next cycle shows IDLE_LEVEL with ser_valid=0; no remaining bits are emitted and the word is not resumed.
- bit_cnt width: $clog2(WIDTH+1). gap_cnt width: $clog2(GAP_CYCLES+1), minimum 1.

Optional Feature:
- Macro: SERIAL_WORD_TX_PARITY_EN.
- When defined:
  - After the last data bit, state PARITY drives ser_out = ^word, even parity over the accepted in_data, latched at accept.
  - In PARITY, ser_valid=1 and ser_last=1; ser_last is not asserted on data bit WIDTH-1.
  - The word occupies WIDTH+1 bit cycles.
- When undefined:
  - No PARITY state and no parity register.
  - ser_last is asserted on data bit WIDTH-1.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 → ser_out=1, ser_valid=0, busy=0, in_ready=0; after release in_ready=1, nothing is captured during reset.
- Single word (WIDTH=8, GAP_CYCLES=1), in_data=8'h36 accepted at edge N → ser_out 0,0,1,1,0,1,1,0 in cycles N+1..N+8; ser_last only in cycle N+8; ser_valid high exactly 8 cycles; in_ready=0 during N+1..N+9.
- Back-to-back: in_valid held high with 8'h6A then 8'h55 → exactly 2 cycles of ser_out=1 (ser_valid=0) between the last bit of 8'h6A and the first bit of 8'h55; both words bit-exact.
- Busy ignore: present 8'hFF with in_valid=1 during bit 3 of 8'h36 → 8'h36 is transmitted unchanged; 8'hFF is accepted only at the next IDLE.
- Reset mid-word: assert rst after 3 bits of 8'hA5 → following cycle ser_out=1, ser_valid=0, busy=0; a new word 8'h0F after release is sent from its MSB.
- With SERIAL_WORD_TX_PARITY_EN: 8'h07 → 8 data bits then parity bit 1 with ser_last=1 on the 9th cycle; 8'h03 → parity bit 0.
